// File: rtl/coeff_block_assembler_pkg.sv
// Shared types and constants for the CAVLC coefficient block assembler.
package cavlc_pkg;
  localparam int LEVEL_W = 13;
  localparam int NCOEFF  = 16;

  typedef logic signed [LEVEL_W-1:0] level_t;

  typedef enum logic [1:0] {COLLECT, FLUSH, WAITBANK} asm_state_t;

  // Raster index -> zigzag scan position for a 4x4 block.
  localparam logic [3:0] RASTER2SCAN [NCOEFF] = '{
    4'd0, 4'd1, 4'd5, 4'd6, 4'd2, 4'd4, 4'd7, 4'd12,
    4'd3, 4'd8, 4'd11, 4'd13, 4'd9, 4'd10, 4'd14, 4'd15
  };
endpackage

// File: rtl/coeff_block_assembler_if.sv
// Decoder-side syntax inputs and dequant-side coefficient stream.
interface coeff_block_assembler_if;
  import cavlc_pkg::*;

  level_t     LevelIn;
  logic       LevelWr;
  logic [4:0] TotalCoeff;
  logic [3:0] TotalZeros;
  logic       TotalZerosWr;
  logic [3:0] RunBefore;
  logic       RunWr;
  logic       BlockDone;
  logic       Stall;
  level_t     CoeffOut;
  logic [3:0] CoeffIdx;
  logic       CoeffValid;
  logic       CoeffReady;
  logic       CoeffLast;
  logic       Error;

  modport master (
    output LevelIn, LevelWr, TotalCoeff, TotalZeros, TotalZerosWr,
           RunBefore, RunWr, BlockDone, CoeffReady,
    input  Stall, CoeffOut, CoeffIdx, CoeffValid, CoeffLast, Error
  );

  modport slave (
    input  LevelIn, LevelWr, TotalCoeff, TotalZeros, TotalZerosWr,
           RunBefore, RunWr, BlockDone, CoeffReady,
    output Stall, CoeffOut, CoeffIdx, CoeffValid, CoeffLast, Error
  );
endinterface

// File: rtl/coeff_block_assembler_bank.sv
// 16-entry coefficient bank indexed by scan position; clear zeroes the whole bank in one edge.
module coeff_bank
  import cavlc_pkg::*;
(
  input  logic       Clk,
  input  logic       nReset,
  input  logic       wrEn,
  input  logic [3:0] wrAddr,
  input  level_t     wrData,
  input  logic       clr,
  input  logic [3:0] rdAddr,
  output level_t     rdData
);
  level_t mem [NCOEFF];

  // Clear wins over write; a bank being drained is never the one being filled.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NCOEFF; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < NCOEFF; i++) mem[i] <= '0;
    end else if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];
endmodule

// File: rtl/coeff_block_assembler.sv
// Places CAVLC levels at their scan positions in a ping-pong bank pair and
// streams each finished block out in raster order.
module coeff_block_assembler
  import cavlc_pkg::*;
(
  input logic                    Clk,
  input logic                    nReset,
  coeff_block_assembler_if.slave bus
);
  asm_state_t        state, stateNext;
  level_t            levStore [NCOEFF];
  logic [4:0]        nLev, nLevNext, k, kNext, tcHold;
  logic signed [4:0] pos, posNext;
  logic              posValid, posValidNext;
  logic              wrBank, wrBankNext, rdBank;
  logic [1:0]        full, fullSet, fullClr, fullNext;
  logic              stall, stallNext, error, errSet;
  logic              levWr, tcLatch, bankWr;
  level_t            bankData;
  logic [5:0]        tcTz, posDec;
  logic              anyIn, xfer, lastXfer;
  logic [3:0]        coeffIdx, scanIdx;
  level_t            bankRd [2];

  assign anyIn    = bus.LevelWr | bus.TotalZerosWr | bus.RunWr | bus.BlockDone;
  assign tcTz     = {1'b0, bus.TotalCoeff} + {2'b00, bus.TotalZeros};
  assign posDec   = {pos[4], pos} - {2'b00, bus.RunBefore} - 6'd1;
  assign xfer     = full[rdBank] & bus.CoeffReady;
  assign lastXfer = xfer & (coeffIdx == 4'd15);
  assign fullClr  = lastXfer ? (2'b01 << rdBank) : 2'b00;
  assign bankData = levStore[k[3:0]];

  // Write FSM: next state, bookkeeping updates and bank write strobe.
  always_comb begin
    stateNext    = state;
    nLevNext     = nLev;
    kNext        = k;
    posNext      = pos;
    posValidNext = posValid;
    wrBankNext   = wrBank;
    fullSet      = 2'b00;
    errSet       = stall & anyIn;
    levWr        = 1'b0;
    tcLatch      = 1'b0;
    bankWr       = 1'b0;
    unique case (state)
      COLLECT: if (!stall) begin
        if (bus.LevelWr) begin
          if (nLev == 5'(NCOEFF)) errSet = 1'b1;
          else begin
            levWr    = 1'b1;
            nLevNext = nLev + 5'd1;
          end
        end
        if (bus.TotalZerosWr) begin
          if (tcTz > 6'd16) errSet = 1'b1;
          else begin
            posNext      = 5'(tcTz - 6'd1);
            kNext        = '0;
            posValidNext = 1'b1;
          end
        end
        if (bus.RunWr) begin
          if (k >= nLev || pos[4]) errSet = 1'b1;
          else begin
            bankWr  = 1'b1;
            // Saturate rather than wrap so a later write still sees a negative Pos.
            posNext = (posDec[5] != posDec[4]) ? 5'b10000 : posDec[4:0];
            kNext   = k + 5'd1;
          end
        end
        if (bus.BlockDone) begin
          tcLatch = 1'b1;
          if (!posValid) posNext = 5'(bus.TotalCoeff - 5'd1);
          stateNext = FLUSH;
        end
      end
      FLUSH: begin
        if (k < tcHold) begin
          if (pos[4]) errSet = 1'b1;
          else begin
            bankWr  = 1'b1;
            posNext = pos - 5'sd1;
          end
          kNext = k + 5'd1;
        end
        if ((k + 5'd1) >= tcHold) begin
          fullSet[wrBank] = 1'b1;
          wrBankNext      = ~wrBank;
          nLevNext        = '0;
          kNext           = '0;
          posValidNext    = 1'b0;
          stateNext       = (full[~wrBank] & ~fullClr[~wrBank]) ? WAITBANK : COLLECT;
        end
      end
      WAITBANK: if (!full[wrBank]) stateNext = COLLECT;
      default: stateNext = COLLECT;
    endcase
  end

  assign fullNext  = (full & ~fullClr) | fullSet;
  assign stallNext = (stateNext != COLLECT) | fullNext[wrBankNext];

  // Write-side state register; Stall is registered from next-state values.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state    <= COLLECT;
      nLev     <= '0;
      k        <= '0;
      pos      <= '0;
      posValid <= 1'b0;
      wrBank   <= 1'b0;
      full     <= 2'b00;
      stall    <= 1'b0;
      error    <= 1'b0;
      tcHold   <= '0;
    end else begin
      state    <= stateNext;
      nLev     <= nLevNext;
      k        <= kNext;
      pos      <= posNext;
      posValid <= posValidNext;
      wrBank   <= wrBankNext;
      full     <= fullNext;
      stall    <= stallNext;
      error    <= error | errSet;
      if (tcLatch) tcHold <= bus.TotalCoeff;
    end
  end

  // Level staging, filled in arrival order (highest scan position first).
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NCOEFF; i++) levStore[i] <= '0;
    end else if (levWr) begin
      levStore[nLev[3:0]] <= bus.LevelIn;
    end
  end

  // Read counter: advance per accepted beat, swap banks after the last one.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      coeffIdx <= '0;
      rdBank   <= 1'b0;
    end else if (xfer) begin
      coeffIdx <= coeffIdx + 4'd1;
      if (lastXfer) rdBank <= ~rdBank;
    end
  end

  assign scanIdx = RASTER2SCAN[coeffIdx];

  for (genvar b = 0; b < 2; b++) begin : gBank
    coeff_bank uBank (
      .Clk    (Clk),
      .nReset (nReset),
      .wrEn   (bankWr & (wrBank == 1'(b))),
      .wrAddr (pos[3:0]),
      .wrData (bankData),
      .clr    (fullClr[b]),
      .rdAddr (scanIdx),
      .rdData (bankRd[b])
    );
  end

  assign bus.Stall      = stall;
  assign bus.Error      = error;
  assign bus.CoeffValid = full[rdBank];
  assign bus.CoeffIdx   = coeffIdx;
  assign bus.CoeffLast  = full[rdBank] & (coeffIdx == 4'd15);
  assign bus.CoeffOut   = bankRd[rdBank];
endmodule

// File: tb/tb_coeff_block_assembler.sv
// Scoreboard bench: drivers push expected raster beats, a negedge monitor pops and compares.
module tb_coeff_block_assembler;
  import cavlc_pkg::*;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  coeff_block_assembler_if bus();
  coeff_block_assembler dut (.Clk(clk), .nReset(rstN), .bus(bus));

  typedef struct { int idx; int val; int last; } beat_t;
  beat_t expQ[$];
  int nChk = 0, nPass = 0;
  int readyMode = 3;  // 0 always, 1 toggle, 2 random, 3 never
  // zigzag: scan position s lands at raster index ZZ[s]
  int ZZ[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

  task automatic chk(string name, int act, int exp);
    nChk++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // Ready pattern generator.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: bus.CoeffReady = 1'b1;
      1: bus.CoeffReady = ~bus.CoeffReady;
      2: bus.CoeffReady = 1'($urandom_range(0, 1));
      default: bus.CoeffReady = 1'b0;
    endcase
  end

  // Monitor: check held beats stay stable, pop and compare accepted beats.
  logic held = 1'b0;
  int hIdx, hVal;
  always @(negedge clk) begin
    if (!rstN) held = 1'b0;
    else begin
      if (held) begin
        chk("hold_valid", int'(bus.CoeffValid), 1);
        chk("hold_idx", int'(bus.CoeffIdx), hIdx);
        chk("hold_out", int'(bus.CoeffOut), hVal);
      end
      if (bus.CoeffValid && bus.CoeffReady) begin
        chk("beat_expected", int'(expQ.size() > 0), 1);
        if (expQ.size() > 0) begin
          beat_t b;
          b = expQ.pop_front();
          chk("beat_idx", int'(bus.CoeffIdx), b.idx);
          chk("beat_val", int'(bus.CoeffOut), b.val);
          chk("beat_last", int'(bus.CoeffLast), b.last);
        end
        held = 1'b0;
      end else if (bus.CoeffValid) begin
        held = 1'b1;
        hIdx = int'(bus.CoeffIdx);
        hVal = int'(bus.CoeffOut);
      end else held = 1'b0;
    end
  end

  // Reference: place levels by scan-position rules, then emit in raster order.
  task automatic pushExp(int tc, int tz, bit hasTz, input int lev[16], input int run[16], int nRun);
    int scan[16];
    int raster[16];
    int p;
    foreach (scan[i]) scan[i] = 0;
    p = hasTz ? tc + tz - 1 : tc - 1;
    for (int i = 0; i < tc; i++) begin
      scan[p] = lev[i];
      p -= (i < nRun) ? run[i] + 1 : 1;
    end
    for (int s = 0; s < 16; s++) raster[ZZ[s]] = scan[s];
    for (int r = 0; r < 16; r++) expQ.push_back('{r, raster[r], int'(r == 15)});
  endtask

  task automatic clearStrobes();
    bus.LevelWr = 1'b0; bus.TotalZerosWr = 1'b0; bus.RunWr = 1'b0; bus.BlockDone = 1'b0;
  endtask

  task automatic waitNoStall();
    int n = 0;
    while (bus.Stall && n < 2000) begin @(posedge clk); #1; n++; end
    chk("stall_release", int'(bus.Stall), 0);
  endtask

  // kind: 0 level, 1 total_zeros, 2 run_before, 3 block done
  task automatic pulse(int kind, int val);
    waitNoStall();
    case (kind)
      0: begin bus.LevelIn = level_t'(val); bus.LevelWr = 1'b1; end
      1: begin bus.TotalZeros = 4'(val); bus.TotalZerosWr = 1'b1; end
      2: begin bus.RunBefore = 4'(val); bus.RunWr = 1'b1; end
      default: bus.BlockDone = 1'b1;
    endcase
    @(posedge clk); #1;
    clearStrobes();
  endtask

  task automatic sendBlock(int tc, int tz, bit hasTz, input int lev[16], input int run[16], int nRun);
    waitNoStall();
    bus.TotalCoeff = 5'(tc);
    for (int i = 0; i < tc; i++) pulse(0, lev[i]);
    if (hasTz) pulse(1, tz);
    for (int i = 0; i < nRun; i++) pulse(2, run[i]);
    pushExp(tc, tz, hasTz, lev, run, nRun);
    pulse(3, 0);
  endtask

  task automatic randBlock();
    int tc, tz, nRun, zl;
    bit hasTz;
    int lev[16];
    int run[16];
    tc = $urandom_range(0, 16);
    hasTz = (tc > 0) && (tc < 16);
    tz = hasTz ? $urandom_range(0, 16 - tc) : 0;
    for (int i = 0; i < 16; i++) begin lev[i] = $urandom_range(0, 8191) - 4096; run[i] = 0; end
    nRun = 0; zl = tz;
    while (nRun < tc - 1 && zl > 0) begin
      run[nRun] = $urandom_range(0, zl);
      zl -= run[nRun];
      nRun++;
    end
    sendBlock(tc, tz, hasTz, lev, run, nRun);
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((expQ.size() > 0 || bus.CoeffValid) && n < 5000) begin @(posedge clk); #1; n++; end
    chk("drain_done", expQ.size(), 0);
  endtask

  task automatic chkResetOutputs(string tag);
    chk({tag, "_valid"}, int'(bus.CoeffValid), 0);
    chk({tag, "_idx"}, int'(bus.CoeffIdx), 0);
    chk({tag, "_last"}, int'(bus.CoeffLast), 0);
    chk({tag, "_out"}, int'(bus.CoeffOut), 0);
    chk({tag, "_stall"}, int'(bus.Stall), 0);
    chk({tag, "_error"}, int'(bus.Error), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", nChk);
    $fatal(1);
  end

  initial begin
    int lev[16];
    int run[16];
    clearStrobes();
    bus.LevelIn = '0; bus.TotalCoeff = '0; bus.TotalZeros = '0; bus.RunBefore = '0;
    repeat (3) @(posedge clk);
    #1;
    chkResetOutputs("reset");
    rstN = 1'b1;
    @(posedge clk); #1;

    // 1: full block, levels 1..16 delivered highest scan position first
    readyMode = 0;
    for (int i = 0; i < 16; i++) begin lev[i] = i + 1; run[i] = 0; end
    sendBlock(16, 0, 1'b0, lev, run, 0);
    waitIdle();

    // 2: empty block, Stall high for exactly one cycle
    sendBlock(0, 0, 1'b0, lev, run, 0);
    chk("t2_stall_hi", int'(bus.Stall), 1);
    @(posedge clk); #1;
    chk("t2_stall_lo", int'(bus.Stall), 0);
    waitIdle();

    // 3: TC=3 TZ=2 with one run
    lev[0] = 5; lev[1] = -3; lev[2] = 1; run[0] = 1;
    sendBlock(3, 2, 1'b1, lev, run, 1);
    waitIdle();

    // 5: ready toggling, then random ready
    readyMode = 1;
    repeat (6) randBlock();
    waitIdle();
    readyMode = 2;
    repeat (10) randBlock();
    waitIdle();
    chk("no_error_yet", int'(bus.Error), 0);

    // 4: two blocks with ready low, then dropped input while stalled
    readyMode = 3;
    repeat (2) @(posedge clk);
    #1;
    randBlock();
    for (int i = 0; i < 16; i++) lev[i] = 100 - 7 * i;
    sendBlock(16, 0, 1'b0, lev, run, 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("t4_stall_held", int'(bus.Stall), 1);
    chk("t4_err_before", int'(bus.Error), 0);
    bus.LevelIn = level_t'(291); bus.LevelWr = 1'b1;
    @(posedge clk); #1;
    clearStrobes();
    chk("t4_err_set", int'(bus.Error), 1);
    readyMode = 0;
    waitIdle();
    chk("t4_stall_free", int'(bus.Stall), 0);
    randBlock();
    waitIdle();

    // 6: reset in the middle of a drain
    readyMode = 3;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) lev[i] = i * 3 - 20;
    sendBlock(16, 0, 1'b0, lev, run, 0);
    readyMode = 0;
    repeat (6) begin @(posedge clk); #1; end
    rstN = 1'b0;
    expQ.delete();
    readyMode = 3;
    repeat (2) begin @(posedge clk); #1; end
    chkResetOutputs("midreset");
    rstN = 1'b1;
    @(posedge clk); #1;
    lev[0] = 5; lev[1] = -3; lev[2] = 1; run[0] = 1;
    sendBlock(3, 2, 1'b1, lev, run, 1);
    readyMode = 0;
    waitIdle();
    repeat (4) randBlock();
    waitIdle();
    chk("final_error", int'(bus.Error), 0);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end
endmodule
